eship_fire_scheduler: RTL and testbench

Decides which enemy ship fires and when, producing the one-hot fire strobe `ESchedFire` and the schedule counter `ESchedCtr` that the enemy projectile controller consumes. A frame-rate period counter triggers a round-robin scan over live ships. The selected ship fires once a projectile slot is free. One scheduler serves the whole enemy formation and sits between formation state (`EShipAlive`) and the projectile pool (`EProjOn`).

---
 rtl/galaga_lib.sv | 29 ++
 rtl/eship_lfsr.sv | 29 ++
 rtl/eship_fire_scheduler.sv | 151 +++++++++++++++
 tb/tb_eship_fire_scheduler.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/galaga_lib.sv
// Shared constants and types for the Galaga enemy logic.
// Holds the formation size, projectile pool size, scheduler state encoding
// and the seed for the optional fire-period jitter LFSR.
package galaga_lib;

  // Enemy formation size and enemy projectile pool size
  localparam int NM   = 8;
  localparam int NPE  = 4;
  localparam int NM_W = (NM > 1) ? $clog2(NM) : 1;

  // Seed loaded into the jitter LFSR on reset; must be non-zero
  localparam logic [7:0] ESCHED_SEED = 8'hA5;

  typedef enum logic [1:0] {
    ESCHED_COUNT,
    ESCHED_SCAN,
    ESCHED_WAIT_SLOT,
    ESCHED_FIRE
  } esched_state_t;

  // Next ship index with wrap from NM-1 back to 0 (NM need not be a power of 2)
  function automatic logic [NM_W-1:0] shipWrapInc(input logic [NM_W-1:0] i);
    if (i == NM_W'(NM - 1)) begin
      return '0;
    end
    return i + NM_W'(1);
  endfunction

endpackage

// File: rtl/eship_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) used to jitter the enemy fire period.
// Seeded non-zero, so it cycles through its 255 non-zero states forever.
module eship_lfsr
  import galaga_lib::*;
(
  input  logic       frame_clk,
  input  logic       Reset,
  output logic [7:0] Lfsr
);

  logic [7:0] lfsr_q, lfsr_d;

  // Shift left and feed the XOR of taps 8,6,5,4 into the low bit
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // Advance one step per frame; reset loads the seed
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      lfsr_q <= ESCHED_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign Lfsr = lfsr_q;

endmodule

// File: rtl/eship_fire_scheduler.sv
// Enemy fire scheduler: counts frames, then round-robin scans the formation
// for the next live ship after the last one that fired, waits for a free
// projectile slot and emits a one-cycle one-hot fire strobe.
// Optional feature: define ESCHED_LFSR_EN to add LFSR jitter to the period.
module eship_fire_scheduler
  import galaga_lib::*;
#(
  parameter int         FIRE_PERIOD = 60,
  parameter logic [7:0] JITTER_MASK = 8'h1F
) (
  input  logic           frame_clk,
  input  logic           Reset,
  input  logic           GameActive,
  input  logic [NM-1:0]  EShipAlive,
  input  logic [NPE-1:0] EProjOn,
  output logic [NM-1:0]  ESchedFire,
  output logic [9:0]     ESchedCtr,
  output logic           ESchedBusy
);

  esched_state_t   state_q, state_d;
  logic [9:0]      ctr_q, ctr_d;
  logic [NM_W-1:0] ptr_q, ptr_d;
  logic [NM_W-1:0] idx_q, idx_d;
  logic [NM_W-1:0] scnt_q, scnt_d;
  logic [NM_W-1:0] sel_q, sel_d;
  logic [9:0]      period;

`ifdef ESCHED_LFSR_EN
  logic [7:0] lfsr;
  logic [9:0] period_q, period_d;

  eship_lfsr u_lfsr (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .Lfsr      (lfsr)
  );

  // Pick a fresh jittered period each time a fire attempt finishes
  always_comb begin
    period_d = period_q;
    if (GameActive && (state_q != ESCHED_COUNT) && (state_d == ESCHED_COUNT)) begin
      period_d = 10'(FIRE_PERIOD) + {2'b00, lfsr & JITTER_MASK};
    end
  end

  // Period register, starts at the nominal period
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      period_q <= 10'(FIRE_PERIOD);
    end else begin
      period_q <= period_d;
    end
  end

  assign period = period_q;
`else
  logic jitterUnused;

  assign period       = 10'(FIRE_PERIOD);
  assign jitterUnused = ^JITTER_MASK;
`endif

  // Next-state logic: count frames, scan for a live ship, wait for a slot, fire
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    scnt_d  = scnt_q;
    sel_d   = sel_q;
    if (!GameActive) begin
      state_d = ESCHED_COUNT;
      ctr_d   = '0;
    end else begin
      case (state_q)
        ESCHED_COUNT: begin
          if (ctr_q == period - 10'd1) begin
            ctr_d   = '0;
            idx_d   = shipWrapInc(ptr_q);
            scnt_d  = '0;
            state_d = ESCHED_SCAN;
          end else begin
            ctr_d = ctr_q + 10'd1;
          end
        end
        ESCHED_SCAN: begin
          ctr_d = '0;
          if (EShipAlive[idx_q]) begin
            sel_d   = idx_q;
            state_d = ESCHED_WAIT_SLOT;
          end else if (scnt_q == NM_W'(NM - 1)) begin
            state_d = ESCHED_COUNT;
          end else begin
            idx_d  = shipWrapInc(idx_q);
            scnt_d = scnt_q + NM_W'(1);
          end
        end
        ESCHED_WAIT_SLOT: begin
          ctr_d = '0;
          if (!EShipAlive[sel_q]) begin
            state_d = ESCHED_COUNT;
            ptr_d   = sel_q;
          end else if (~&EProjOn) begin
            state_d = ESCHED_FIRE;
          end
        end
        ESCHED_FIRE: begin
          ctr_d   = '0;
          ptr_d   = sel_q;
          state_d = ESCHED_COUNT;
        end
        default: begin
          state_d = ESCHED_COUNT;
          ctr_d   = '0;
        end
      endcase
    end
  end

  // Scheduler registers; ptr starts at the last ship so the first scan begins at ship 0
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q <= ESCHED_COUNT;
      ctr_q   <= '0;
      ptr_q   <= NM_W'(NM - 1);
      idx_q   <= '0;
      scnt_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      scnt_q  <= scnt_d;
      sel_q   <= sel_d;
    end
  end

  // One-hot strobe only in FIRE and only while the game is running
  always_comb begin
    ESchedFire = '0;
    if ((state_q == ESCHED_FIRE) && GameActive) begin
      ESchedFire = NM'(1) << sel_q;
    end
  end

  assign ESchedCtr  = ctr_q;
  assign ESchedBusy = (state_q != ESCHED_COUNT);

endmodule

// File: tb/tb_eship_fire_scheduler.sv
// Directed self-checking bench for eship_fire_scheduler (FIRE_PERIOD = 4).
// Cycle 1 is the first cycle after reset release; outputs are sampled on
// the falling edge, inputs change on the falling edge.
module tb_eship_fire_scheduler;
  import galaga_lib::*;

  logic           frame_clk = 1'b0;
  logic           Reset = 1'b1;
  logic           GameActive = 1'b0;
  logic [NM-1:0]  EShipAlive = '0;
  logic [NPE-1:0] EProjOn = '0;
  logic [NM-1:0]  ESchedFire;
  logic [9:0]     ESchedCtr;
  logic           ESchedBusy;

  int cycle = 0;
  int checks = 0;
  int passes = 0;

  eship_fire_scheduler #(
    .FIRE_PERIOD (4),
    .JITTER_MASK (8'h1F)
  ) dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .GameActive (GameActive),
    .EShipAlive (EShipAlive),
    .EProjOn    (EProjOn),
    .ESchedFire (ESchedFire),
    .ESchedCtr  (ESchedCtr),
    .ESchedBusy (ESchedBusy)
  );

  // Free-running frame clock
  always #5 frame_clk = ~frame_clk;

  // Safety net so a broken design can never hang the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NM-1:0] alive, input logic [NPE-1:0] proj, input logic ga);
    EShipAlive = alive;
    EProjOn    = proj;
    GameActive = ga;
  endtask

  task automatic step();
    @(negedge frame_clk);
    cycle++;
  endtask

  task automatic doReset();
    Reset = 1'b1;
    @(posedge frame_clk);
    @(posedge frame_clk);
    @(negedge frame_clk);
    Reset = 1'b0;
    cycle = 1;
  endtask

  logic [NM-1:0] expFire;
  logic          expBusy;

  initial begin
    // A: all alive, free slots -> ships 0,1,2 fire at cycles 7,14,21
    applyStimulus(8'hFF, 4'h0, 1'b1);
    doReset();
    checkOutput("A reset ctr", 16'(ESchedCtr), 16'd0);
    checkOutput("A reset busy", 16'(ESchedBusy), 16'd0);
    for (int i = 0; i < 21; i++) begin
      expFire = (cycle == 7) ? 8'h01 : (cycle == 14) ? 8'h02 : (cycle == 21) ? 8'h04 : 8'h00;
      checkOutput($sformatf("A fire c%0d", cycle), 16'(ESchedFire), 16'(expFire));
      if (cycle == 4) checkOutput("A ctr at trigger", 16'(ESchedCtr), 16'd3);
      if (cycle == 5) checkOutput("A busy in scan", 16'(ESchedBusy), 16'd1);
      step();
    end
    checkOutput("A ctr after fire", 16'(ESchedCtr), 16'd0);
    checkOutput("A busy after fire", 16'(ESchedBusy), 16'd0);

    // B: after ship 0 fires, only ships 7 and 0 alive -> 8'h80 six cycles late, then wrap to 8'h01
    applyStimulus(8'hFF, 4'h0, 1'b1);
    doReset();
    for (int i = 0; i < 27; i++) begin
      expFire = (cycle == 7) ? 8'h01 : (cycle == 20) ? 8'h80 : (cycle == 27) ? 8'h01 : 8'h00;
      checkOutput($sformatf("B fire c%0d", cycle), 16'(ESchedFire), 16'(expFire));
      if (cycle == 8) EShipAlive = 8'b1000_0001;
      step();
    end

    // C: no ships alive -> 8-cycle scans, no strobe ever
    applyStimulus(8'h00, 4'h0, 1'b1);
    doReset();
    for (int i = 0; i < 30; i++) begin
      expBusy = ((cycle >= 5) && (cycle <= 12)) || ((cycle >= 17) && (cycle <= 24)) || (cycle >= 29);
      checkOutput($sformatf("C busy c%0d", cycle), 16'(ESchedBusy), 16'(expBusy));
      checkOutput($sformatf("C fire c%0d", cycle), 16'(ESchedFire), 16'd0);
      step();
    end

    // D: pool full for 20 cycles of WAIT_SLOT, then slot 0 frees
    applyStimulus(8'hFF, 4'hF, 1'b1);
    doReset();
    for (int i = 0; i < 26; i++) begin
      expBusy = (cycle >= 5);
      expFire = (cycle == 26) ? 8'h01 : 8'h00;
      checkOutput($sformatf("D busy c%0d", cycle), 16'(ESchedBusy), 16'(expBusy));
      checkOutput($sformatf("D fire c%0d", cycle), 16'(ESchedFire), 16'(expFire));
      if (cycle == 25) EProjOn = 4'hE;
      step();
    end
    checkOutput("D busy after fire", 16'(ESchedBusy), 16'd0);
    checkOutput("D ctr after fire", 16'(ESchedCtr), 16'd0);

    // E: kill ship 0 while it waits for a slot -> abort, next scan starts at ship 1
    applyStimulus(8'hFF, 4'hF, 1'b1);
    doReset();
    for (int i = 0; i < 16; i++) begin
      expBusy = ((cycle >= 5) && (cycle <= 8)) || ((cycle >= 13) && (cycle <= 15));
      expFire = (cycle == 15) ? 8'h02 : 8'h00;
      checkOutput($sformatf("E busy c%0d", cycle), 16'(ESchedBusy), 16'(expBusy));
      checkOutput($sformatf("E fire c%0d", cycle), 16'(ESchedFire), 16'(expFire));
      if (cycle == 9) begin
        checkOutput("E ctr after abort", 16'(ESchedCtr), 16'd0);
        EProjOn = 4'h0;
      end
      if (cycle == 8) EShipAlive = 8'hFE;
      step();
    end

    // F: GameActive drop mid-scan, then reset during FIRE; ptr must return to 7
    applyStimulus(8'h10, 4'h0, 1'b1);
    doReset();
    for (int i = 0; i < 17; i++) begin
      expBusy = ((cycle >= 5) && (cycle <= 6)) || (cycle >= 11);
      expFire = (cycle == 17) ? 8'h10 : 8'h00;
      checkOutput($sformatf("F busy c%0d", cycle), 16'(ESchedBusy), 16'(expBusy));
      checkOutput($sformatf("F fire c%0d", cycle), 16'(ESchedFire), 16'(expFire));
      if (cycle == 7) begin
        checkOutput("F ctr after halt", 16'(ESchedCtr), 16'd0);
        GameActive = 1'b1;
      end
      if (cycle == 6) GameActive = 1'b0;
      if (cycle == 17) begin
        Reset = 1'b1;
        EShipAlive = 8'hFF;
      end
      if (i < 16) step();
    end
    @(negedge frame_clk);
    checkOutput("F reset fire", 16'(ESchedFire), 16'd0);
    checkOutput("F reset ctr", 16'(ESchedCtr), 16'd0);
    checkOutput("F reset busy", 16'(ESchedBusy), 16'd0);
    Reset = 1'b0;
    cycle = 1;
    for (int i = 0; i < 8; i++) begin
      expFire = (cycle == 7) ? 8'h01 : 8'h00;
      checkOutput($sformatf("F post-reset fire c%0d", cycle), 16'(ESchedFire), 16'(expFire));
      step();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
